// File: rtl/am2950_port_if.sv
// am2950_port_if: bus bundle for the Am2950-style two-channel mailbox port.
//
// Carries both channel data paths, their handshake strobes, status flags,
// interrupt enables and active-low interrupts, plus the shared overrun clear.
//   Channel AB (A writes, B reads): a_in, wab_, b_out, rab_, fab, ovab, ieab, int_ab_
//   Channel BA (B writes, A reads): b_in, wba_, a_out, rba_, fba, ovba, ieba, int_ba_
//   Shared:                         clrov_
// Modports:
//   master - the surroundings (both sides plus control); drives writes/reads/enables.
//   slave  - the port itself; drives holding registers, flags and interrupts.
interface am2950_port_if #(
  parameter int unsigned WIDTH = 8
);

  // Channel AB
  logic [WIDTH-1:0] a_in;
  logic             wab_;
  logic [WIDTH-1:0] b_out;
  logic             rab_;
  logic             fab;
  logic             ovab;
  logic             ieab;
  logic             int_ab_;

  // Channel BA
  logic [WIDTH-1:0] b_in;
  logic             wba_;
  logic [WIDTH-1:0] a_out;
  logic             rba_;
  logic             fba;
  logic             ovba;
  logic             ieba;
  logic             int_ba_;

  // Shared overrun clear
  logic             clrov_;

  modport master (
    output a_in, wab_, rab_, ieab,
    output b_in, wba_, rba_, ieba,
    output clrov_,
    input  b_out, fab, ovab, int_ab_,
    input  a_out, fba, ovba, int_ba_
  );

  modport slave (
    input  a_in, wab_, rab_, ieab,
    input  b_in, wba_, rba_, ieba,
    input  clrov_,
    output b_out, fab, ovab, int_ab_,
    output a_out, fba, ovba, int_ba_
  );

endinterface

// File: rtl/am2950_port.sv
// am2950_port: synchronous bidirectional handshake I/O port with two
// independent WIDTH-bit mailbox channels.
//
// Channel AB moves data from the A side to the B side, channel BA from B to A.
// Each channel is a single holding register with an empty/full state, a sticky
// overrun flag and an active-low interrupt gated by a level interrupt enable.
//
// Ports:
//   clk   - system clock, all state changes on the rising edge.
//   rst_  - asynchronous active-low reset; clears registers, flags and state.
//   bus   - am2950_port_if.slave bundle (data, strobes, flags, interrupts).
//
// Per-channel behaviour (w = write strobe, r = read acknowledge):
//   empty, w       -> load data, become full (r is irrelevant, the write wins)
//   empty, r only  -> ignored
//   full,  r only  -> become empty, data kept on the output
//   full,  w only  -> data kept, overrun set
//   full,  w and r -> load data, stay full, no overrun
// Overrun flags are sticky; clrov_ clears both, but a same-edge overrun wins.
module am2950_port #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_,
  am2950_port_if.slave bus
);

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } chan_st_e;

  // ---------------------------------------------------------------------------
  // Decoded strobes (all active-low on the bus)
  // ---------------------------------------------------------------------------
  logic wr_ab, rd_ab;
  logic wr_ba, rd_ba;
  logic clr_ov;

  assign wr_ab  = ~bus.wab_;
  assign rd_ab  = ~bus.rab_;
  assign wr_ba  = ~bus.wba_;
  assign rd_ba  = ~bus.rba_;
  assign clr_ov = ~bus.clrov_;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  chan_st_e         st_ab_d, st_ab_q;
  logic [WIDTH-1:0] data_ab_d, data_ab_q;
  logic             ov_ab_d, ov_ab_q;

  chan_st_e         st_ba_d, st_ba_q;
  logic [WIDTH-1:0] data_ba_d, data_ba_q;
  logic             ov_ba_d, ov_ba_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      st_ab_q   <= StEmpty;
      data_ab_q <= '0;
      ov_ab_q   <= 1'b0;
      st_ba_q   <= StEmpty;
      data_ba_q <= '0;
      ov_ba_q   <= 1'b0;
    end else begin
      st_ab_q   <= st_ab_d;
      data_ab_q <= data_ab_d;
      ov_ab_q   <= ov_ab_d;
      st_ba_q   <= st_ba_d;
      data_ba_q <= data_ba_d;
      ov_ba_q   <= ov_ba_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Channel AB next state
  // ---------------------------------------------------------------------------
  always_comb begin
    st_ab_d   = st_ab_q;
    data_ab_d = data_ab_q;
    ov_ab_d   = ov_ab_q;

    // Clear first so a same-edge overrun below overrides it.
    if (clr_ov) begin
      ov_ab_d = 1'b0;
    end

    unique case (st_ab_q)
      StEmpty: begin
        if (wr_ab) begin
          data_ab_d = bus.a_in;
          st_ab_d   = StFull;
        end
      end
      StFull: begin
        if (wr_ab && rd_ab) begin
          // Reader drains the old word on the same edge the new one lands.
          data_ab_d = bus.a_in;
        end else if (wr_ab) begin
          ov_ab_d = 1'b1;
        end else if (rd_ab) begin
          st_ab_d = StEmpty;
        end
      end
      default: begin
        st_ab_d = StEmpty;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Channel BA next state
  // ---------------------------------------------------------------------------
  always_comb begin
    st_ba_d   = st_ba_q;
    data_ba_d = data_ba_q;
    ov_ba_d   = ov_ba_q;

    if (clr_ov) begin
      ov_ba_d = 1'b0;
    end

    unique case (st_ba_q)
      StEmpty: begin
        if (wr_ba) begin
          data_ba_d = bus.b_in;
          st_ba_d   = StFull;
        end
      end
      StFull: begin
        if (wr_ba && rd_ba) begin
          data_ba_d = bus.b_in;
        end else if (wr_ba) begin
          ov_ba_d = 1'b1;
        end else if (rd_ba) begin
          st_ba_d = StEmpty;
        end
      end
      default: begin
        st_ba_d = StEmpty;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs; interrupts are purely combinational so an enable change is seen
  // without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  logic full_ab, full_ba;

  assign full_ab = (st_ab_q == StFull);
  assign full_ba = (st_ba_q == StFull);

  assign bus.b_out   = data_ab_q;
  assign bus.fab     = full_ab;
  assign bus.ovab    = ov_ab_q;
  assign bus.int_ab_ = ~(full_ab & bus.ieab);

  assign bus.a_out   = data_ba_q;
  assign bus.fba     = full_ba;
  assign bus.ovba    = ov_ba_q;
  assign bus.int_ba_ = ~(full_ba & bus.ieba);

endmodule

// File: tb/tb_am2950_port.sv
// tb_am2950_port: directed self-checking bench for am2950_port.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too,
// well away from the next active edge.
module tb_am2950_port;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst_;

  int n_tests;
  int n_fail;

  am2950_port_if #(.WIDTH(WIDTH)) bus ();

  am2950_port #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wab_   = 1'b1;
    bus.rab_   = 1'b1;
    bus.wba_   = 1'b1;
    bus.rba_   = 1'b1;
    bus.clrov_ = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset with random inputs toggling
    rst_       = 1'b0;
    bus.a_in   = 8'($urandom);
    bus.b_in   = 8'($urandom);
    bus.wab_   = 1'b0;
    bus.rab_   = 1'b1;
    bus.wba_   = 1'b0;
    bus.rba_   = 1'b1;
    bus.ieab   = 1'b1;
    bus.ieba   = 1'b1;
    bus.clrov_ = 1'b1;
    tick();
    bus.a_in = 8'($urandom);
    bus.b_in = 8'($urandom);
    bus.wab_ = 1'($urandom);
    bus.wba_ = 1'($urandom);
    tick();
    check_eq("rst_b_out", 32'(bus.b_out), 32'h00);
    check_eq("rst_a_out", 32'(bus.a_out), 32'h00);
    check_eq("rst_fab", 32'(bus.fab), 32'h0);
    check_eq("rst_fba", 32'(bus.fba), 32'h0);
    check_eq("rst_ovab", 32'(bus.ovab), 32'h0);
    check_eq("rst_ovba", 32'(bus.ovba), 32'h0);
    check_eq("rst_int_ab", 32'(bus.int_ab_), 32'h1);
    check_eq("rst_int_ba", 32'(bus.int_ba_), 32'h1);

    idle_inputs();
    bus.ieab = 1'b1;
    bus.ieba = 1'b0;
    rst_     = 1'b1;
    tick();

    // Basic AB transfer
    bus.a_in = 8'hA5;
    bus.wab_ = 1'b0;
    tick();
    bus.wab_ = 1'b1;
    check_eq("wr_b_out", 32'(bus.b_out), 32'hA5);
    check_eq("wr_fab", 32'(bus.fab), 32'h1);
    check_eq("wr_int_ab", 32'(bus.int_ab_), 32'h0);
    bus.rab_ = 1'b0;
    tick();
    bus.rab_ = 1'b1;
    check_eq("rd_fab", 32'(bus.fab), 32'h0);
    check_eq("rd_b_out_kept", 32'(bus.b_out), 32'hA5);
    check_eq("rd_int_ab", 32'(bus.int_ab_), 32'h1);

    // Overrun
    bus.a_in = 8'h11;
    bus.wab_ = 1'b0;
    tick();
    bus.a_in = 8'h22;
    tick();
    bus.wab_ = 1'b1;
    check_eq("ov_b_out", 32'(bus.b_out), 32'h11);
    check_eq("ov_ovab", 32'(bus.ovab), 32'h1);
    check_eq("ov_fab", 32'(bus.fab), 32'h1);
    bus.clrov_ = 1'b0;
    tick();
    bus.clrov_ = 1'b1;
    check_eq("clrov_ovab", 32'(bus.ovab), 32'h0);
    // Still full with 0x11: overrun and clear on the same edge
    bus.clrov_ = 1'b0;
    bus.a_in   = 8'h55;
    bus.wab_   = 1'b0;
    tick();
    idle_inputs();
    check_eq("ov_dominates", 32'(bus.ovab), 32'h1);
    check_eq("ov_dom_b_out", 32'(bus.b_out), 32'h11);
    bus.clrov_ = 1'b0;
    bus.rab_   = 1'b0;
    tick();
    idle_inputs();
    check_eq("clr_rd_ovab", 32'(bus.ovab), 32'h0);
    check_eq("clr_rd_fab", 32'(bus.fab), 32'h0);

    // Simultaneous write and read while full
    bus.a_in = 8'h33;
    bus.wab_ = 1'b0;
    tick();
    bus.wab_ = 1'b1;
    check_eq("sim_pre_b_out", 32'(bus.b_out), 32'h33);
    bus.a_in = 8'h44;
    bus.wab_ = 1'b0;
    bus.rab_ = 1'b0;
    tick();
    idle_inputs();
    check_eq("sim_full_b_out", 32'(bus.b_out), 32'h44);
    check_eq("sim_full_fab", 32'(bus.fab), 32'h1);
    check_eq("sim_full_ovab", 32'(bus.ovab), 32'h0);
    bus.rab_ = 1'b0;
    tick();
    bus.rab_ = 1'b1;
    check_eq("drain_fab", 32'(bus.fab), 32'h0);

    // Simultaneous write and read while empty: write wins
    bus.a_in = 8'h66;
    bus.wab_ = 1'b0;
    bus.rab_ = 1'b0;
    tick();
    idle_inputs();
    check_eq("sim_empty_fab", 32'(bus.fab), 32'h1);
    check_eq("sim_empty_b_out", 32'(bus.b_out), 32'h66);
    bus.rab_ = 1'b0;
    tick();
    check_eq("drain2_fab", 32'(bus.fab), 32'h0);
    // Read while empty is ignored
    tick();
    bus.rab_ = 1'b1;
    check_eq("empty_rd_fab", 32'(bus.fab), 32'h0);
    check_eq("empty_rd_b_out", 32'(bus.b_out), 32'h66);

    // Streaming 0..15 with acknowledge every cycle; BA loaded mid-stream
    bus.a_in = 8'h00;
    bus.wab_ = 1'b0;
    tick();
    check_eq("stream_b_out_0", 32'(bus.b_out), 32'h00);
    for (int i = 1; i < 16; i++) begin
      bus.a_in = 8'(i);
      bus.rab_ = 1'b0;
      if (i == 3) begin
        bus.b_in = 8'h5A;
        bus.wba_ = 1'b0;
      end else begin
        bus.wba_ = 1'b1;
      end
      tick();
      check_eq("stream_b_out", 32'(bus.b_out), 32'(i));
      check_eq("stream_fab", 32'(bus.fab), 32'h1);
    end
    idle_inputs();
    tick();
    check_eq("stream_ovab", 32'(bus.ovab), 32'h0);
    check_eq("stream_last", 32'(bus.b_out), 32'h0F);
    check_eq("ba_a_out", 32'(bus.a_out), 32'h5A);
    check_eq("ba_fba", 32'(bus.fba), 32'h1);
    check_eq("ba_ovba", 32'(bus.ovba), 32'h0);

    // Interrupt masking, combinational enable path
    check_eq("mask_int_ba", 32'(bus.int_ba_), 32'h1);
    bus.ieba = 1'b1;
    #1;
    check_eq("unmask_int_ba", 32'(bus.int_ba_), 32'h0);
    bus.ieab = 1'b0;
    #1;
    check_eq("mask_int_ab", 32'(bus.int_ab_), 32'h1);
    bus.ieab = 1'b1;

    // BA overrun, independent of AB
    bus.b_in = 8'h77;
    bus.wba_ = 1'b0;
    tick();
    bus.wba_ = 1'b1;
    check_eq("ba_ov_ovba", 32'(bus.ovba), 32'h1);
    check_eq("ba_ov_a_out", 32'(bus.a_out), 32'h5A);
    check_eq("ba_ov_ovab", 32'(bus.ovab), 32'h0);
    bus.rba_ = 1'b0;
    tick();
    bus.rba_ = 1'b1;
    check_eq("ba_rd_fba", 32'(bus.fba), 32'h0);
    check_eq("ba_rd_a_out", 32'(bus.a_out), 32'h5A);
    check_eq("ba_rd_int", 32'(bus.int_ba_), 32'h1);

    // Asynchronous reset mid-cycle while fab=1
    check_eq("pre_arst_fab", 32'(bus.fab), 32'h1);
    #2;
    rst_ = 1'b0;
    #1;
    check_eq("arst_fab", 32'(bus.fab), 32'h0);
    check_eq("arst_b_out", 32'(bus.b_out), 32'h00);
    check_eq("arst_ovba", 32'(bus.ovba), 32'h0);
    check_eq("arst_int_ab", 32'(bus.int_ab_), 32'h1);
    tick();
    rst_ = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/am2950_port.md
# am2950_port

Synchronous bidirectional handshake I/O port of the Am2950 type, with two independent WIDTH-bit mailbox channels. Channel AB carries data from the A side to the B side; channel BA carries data from B to A. Each channel is loaded by its writer and drained by its reader. A full flag, an overrun flag and an active-low interrupt per channel coordinate the two ends. The block sits between a microprogrammed bitslice datapath and an external bus, as the reading/handshaking end paired with enable-loaded registers.

## Interface
- WIDTH, 8, data width of each channel.
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_  input  1  asynchronous, active-low reset.
- a_in  input  WIDTH  A-side write data for channel AB.
- wab_  input  1  active-low write enable for channel AB.
- b_out  output  WIDTH  channel AB holding register, presented to the B side.
- rab_  input  1  active-low read acknowledge from the B side; empties channel AB.
- fab  output  1  channel AB full flag.
- ovab  output  1  channel AB sticky overrun flag.
- ieab  input  1  channel AB interrupt enable (level).
- int_ab_  output  1  active-low interrupt to the B side; equals ~(fab & ieab).
- b_in, wba_, a_out, rba_, fba, ovba, ieba, int_ba_: same definitions for channel BA, with A and B swapped.
- clrov_  input  1  active-low synchronous clear of both overrun flags.

## Operation
- The two channels are identical and fully independent; only clrov_ is shared.
- Per-channel state is empty (f=0) or full (f=1).
- In empty, write asserted: the register loads the input data and f becomes 1.
- In empty, read asserted with no write: ignored; register and f unchanged.
- In full, read asserted with no write: f becomes 0. The register keeps its last value, so b_out/a_out are not cleared.
- In full, write asserted with no read: the register is not loaded and the old data is preserved. The overrun flag is set to 1.
- In full, write and read asserted in the same cycle: the register loads the new data, f stays 1 and no overrun is raised.
- In empty, write and read asserted in the same cycle: the write wins; the register loads and f becomes 1.
- Overrun flags are sticky. clrov_ low clears both on the next edge.
- If clrov_ is low in the same cycle an overrun is detected, the overrun flag is set (set dominates).
- int_x_ is combinational from f and ie and carries no extra register stage.
- Write, read and clrov_ inputs are sampled only at the rising clk edge; levels between edges have no effect.

## Timing
- Reset (rst_ low, asynchronous, at any time including mid-transfer):
  - b_out = 0, a_out = 0.
  - fab = fba = 0, ovab = ovba = 0.
  - int_ab_ = int_ba_ = 1.
  - These values hold while rst_ is low, regardless of clk and the other inputs.
- Write latency: data written at edge N is visible on the output and the flag is set after edge N, so the reader can acknowledge at edge N+1 at the earliest.
- Read latency: the flag clears after the acknowledging edge. A new write can be accepted at that same edge, giving 1 transfer per cycle sustained.
- Interrupt timing: int_x_ changes in the same cycle as f, or immediately when ie changes.
- Release of rst_ takes effect at the next rising edge; no inputs are sampled at the release edge.

## Test plan
- Reset: drive inputs random with rst_ low -> all outputs are 0, both int_ are 1; assert rst_ mid-cycle while fab=1 -> fab drops with no clk edge.
- Basic AB transfer, WIDTH=8:
  - a_in=8'hA5, wab_=0 for one edge -> b_out=A5, fab=1, int_ab_=0 with ieab=1.
  - rab_=0 for one edge -> fab=0, b_out remains A5, int_ab_=1.
- Overrun: write 8'h11, then write 8'h22 without a read -> b_out=11, ovab=1, fab=1.
  - Pulse clrov_ -> ovab=0.
  - clrov_ low in the same edge as a new overrun -> ovab=1.
- Simultaneous events:
  - While full with 8'h33, wab_=0 and rab_=0 with a_in=8'h44 -> b_out=44, fab=1, ovab=0.
  - While empty, write and read together -> fab=1.
- Streaming and channel independence: write every cycle with an acknowledge every cycle for 16 words 0..15 -> b_out sequence matches and ovab stays 0. Meanwhile channel BA loads 8'h5A and a_out=5A, fba=1 with no effect on AB.
- Interrupt masking: fba=1 with ieba=0 -> int_ba_=1; set ieba=1 -> int_ba_=0 combinationally, without waiting for a clock edge.
